// File: rtl/ct_spsram_init_param.sv
// ct_spsram_init_param
// Parametrised single-port SRAM with per-group write enables, an optional
// output pipeline stage and a clear-on-reset sequencer. The sequencer owns
// the array after reset. It walks every address writing INIT_VAL. While it
// does so, all external access ports are ignored and Q holds its reset value.
//
// Access handshake: there is no valid/ready pair. An access is accepted on a
// rising edge whenever init_done=1 and CEN=0. GWEN=0 selects a write and
// GWEN=1 selects a read. Read data appears on Q one edge later, or two edges
// later with OUT_REG=1. Q then holds until the next read result arrives.
module ct_spsram_init_param #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 22,
  parameter int                    WE_WIDTH   = 22,
  parameter bit                    OUT_REG    = 1'b0,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int G     = DATA_WIDTH / WE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_DONE;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    acc_en;
  logic                    rd_en;
  logic                    wr_en;

  assign acc_en    = (state == ST_DONE) && !CEN;
  assign rd_en     = acc_en && GWEN;
  assign wr_en     = acc_en && !GWEN;
  assign init_done = (state == ST_DONE);

  // Sequencer state register; reset always restarts the clear from address 0.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave INIT on the edge that clears the last address.
  always_comb begin
    state_nxt = state;
    if ((state == ST_INIT) && (init_cnt == LAST_ADDR)) begin
      state_nxt = ST_DONE;
    end
  end

  // Clear pointer; it parks on the last address instead of wrapping.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      init_cnt <= '0;
    end else if ((state == ST_INIT) && (init_cnt != LAST_ADDR)) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  // Array writes: the sequencer has priority; user writes are masked per group.
  always_ff @(posedge forever_cpuclk) begin
    if (state == ST_INIT) begin
      mem[init_cnt] <= INIT_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (!WEN[i]) begin
          mem[A][i*G +: G] <= D[i*G +: G];
        end
      end
    end
  end

  // Read register: captures only on an accepted read, otherwise holds.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[A];
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic                  rd_vld;
      logic [DATA_WIDTH-1:0] q_pipe;

      // Second stage loads only when stage 1 holds a fresh read result.
      always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
          rd_vld <= 1'b0;
          q_pipe <= '0;
        end else begin
          rd_vld <= rd_en;
          if (rd_vld) begin
            q_pipe <= rd_q;
          end
        end
      end

      assign Q = q_pipe;
    end else begin : g_no_out_reg
      assign Q = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_ct_spsram_init_param.sv
// Directed bench for ct_spsram_init_param. Four instances cover the default
// 512x22 array, a two-group write mask, the output pipeline stage with a
// non-zero clear pattern, and the no-init configuration.
module tb_ct_spsram_init_param;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  // u0: defaults (512 x 22, per-bit WEN, OUT_REG=0, INIT_EN=1, INIT_VAL=0)
  logic        c0, g0;
  logic [21:0] w0, d0, q0;
  logic [8:0]  a0;
  logic        dn0;
  // u1: WE_WIDTH=2, 16 deep
  logic        c1, g1;
  logic [1:0]  w1;
  logic [21:0] d1, q1;
  logic [3:0]  a1;
  logic        dn1;
  // u2: OUT_REG=1, INIT_VAL=0x155555, 16 deep
  logic        c2, g2;
  logic [21:0] w2, d2, q2;
  logic [3:0]  a2;
  logic        dn2;
  // u3: INIT_EN=0, 16 deep
  logic        c3, g3;
  logic [21:0] w3, d3, q3;
  logic [3:0]  a3;
  logic        dn3;

  ct_spsram_init_param u0 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .CEN(c0), .GWEN(g0), .WEN(w0),
    .A(a0), .D(d0), .Q(q0), .init_done(dn0)
  );

  ct_spsram_init_param #(.ADDR_WIDTH(4), .WE_WIDTH(2)) u1 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .CEN(c1), .GWEN(g1), .WEN(w1),
    .A(a1), .D(d1), .Q(q1), .init_done(dn1)
  );

  ct_spsram_init_param #(.ADDR_WIDTH(4), .OUT_REG(1'b1), .INIT_VAL(22'h155555)) u2 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .CEN(c2), .GWEN(g2), .WEN(w2),
    .A(a2), .D(d2), .Q(q2), .init_done(dn2)
  );

  ct_spsram_init_param #(.ADDR_WIDTH(4), .INIT_EN(1'b0)) u3 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .CEN(c3), .GWEN(g3), .WEN(w3),
    .A(a3), .D(d3), .Q(q3), .init_done(dn3)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc0(input logic cen, input logic gwen, input logic [21:0] wen,
                      input logic [8:0] a, input logic [21:0] d);
    c0 = cen; g0 = gwen; w0 = wen; a0 = a; d0 = d;
    tick();
  endtask

  task automatic acc1(input logic cen, input logic gwen, input logic [1:0] wen,
                      input logic [3:0] a, input logic [21:0] d);
    c1 = cen; g1 = gwen; w1 = wen; a1 = a; d1 = d;
    tick();
  endtask

  task automatic acc2(input logic cen, input logic gwen, input logic [21:0] wen,
                      input logic [3:0] a, input logic [21:0] d);
    c2 = cen; g2 = gwen; w2 = wen; a2 = a; d2 = d;
    tick();
  endtask

  task automatic acc3(input logic cen, input logic gwen, input logic [21:0] wen,
                      input logic [3:0] a, input logic [21:0] d);
    c3 = cen; g3 = gwen; w3 = wen; a3 = a; d3 = d;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    c0 = 1'b1; g0 = 1'b1; w0 = '1; a0 = '0; d0 = '0;
    c1 = 1'b1; g1 = 1'b1; w1 = '1; a1 = '0; d1 = '0;
    c2 = 1'b1; g2 = 1'b1; w2 = '1; a2 = '0; d2 = '0;
    c3 = 1'b1; g3 = 1'b1; w3 = '1; a3 = '0; d3 = '0;
    repeat (3) tick();

    // Reset values
    chk("rst_q0", q0, 0);
    chk("rst_done0", dn0, 0);
    chk("rst_done1", dn1, 0);
    chk("rst_q2", q2, 0);
    chk("rst_done3", dn3, 1);

    // Release between edges; the next edge is the first clear write.
    rst_n = 1'b1;

    // Accesses during INIT must be ignored (write to 3, then a read attempt).
    for (int i = 0; i < 10; i++) acc0(1'b0, 1'b0, 22'h0, 9'h003, 22'h2AAAAA);
    for (int i = 0; i < 5; i++) acc0(1'b0, 1'b1, 22'h0, 9'h003, 22'h0);
    chk("init_q_hold", q0, 0);
    chk("init_busy0", dn0, 0);
    c0 = 1'b1; g0 = 1'b1; w0 = '1;
    repeat (511 - 15) tick();
    chk("init_511", dn0, 0);
    tick();
    chk("init_512", dn0, 1);
    chk("init_done1", dn1, 1);
    chk("init_done2", dn2, 1);

    // Default array: boundary read, masked write, hold, read-after-write.
    acc0(1'b0, 1'b1, 22'h3FFFFF, 9'h1FF, 22'h0);
    chk("rd_1ff", q0, 0);
    acc0(1'b0, 1'b0, 22'h000000, 9'h005, 22'h3FFFFF);
    chk("wr_no_q_change", q0, 0);
    acc0(1'b0, 1'b0, 22'h3FF800, 9'h005, 22'h000000);
    acc0(1'b0, 1'b1, 22'h3FFFFF, 9'h005, 22'h0);
    chk("mask_rd5", q0, 22'h3FF800);
    for (int i = 0; i < 3; i++) begin
      acc0(1'b1, 1'b1, 22'h0, 9'h005, 22'h0);
      chk("cen_hold", q0, 22'h3FF800);
    end
    acc0(1'b0, 1'b0, 22'h000000, 9'h006, 22'h000123);
    chk("wr6_no_wt", q0, 22'h3FF800);
    acc0(1'b0, 1'b1, 22'h000000, 9'h006, 22'h0);
    chk("raw_rd6", q0, 22'h000123);
    acc0(1'b0, 1'b1, 22'h3FFFFF, 9'h003, 22'h0);
    chk("init_wr_ignored", q0, 22'h0);
    acc0(1'b0, 1'b0, 22'h3FFFFF, 9'h007, 22'h3FFFFF);
    acc0(1'b0, 1'b1, 22'h3FFFFF, 9'h007, 22'h0);
    chk("noop_write", q0, 22'h0);
    acc0(1'b0, 1'b0, 22'h000000, 9'h050, 22'h02AAAA);
    acc0(1'b0, 1'b1, 22'h3FFFFF, 9'h050, 22'h0);
    chk("rd_050", q0, 22'h02AAAA);
    acc0(1'b1, 1'b1, 22'h3FFFFF, 9'h0, 22'h0);

    // Two-group write mask.
    acc1(1'b0, 1'b0, 2'b00, 4'h2, 22'h3FFFFF);
    acc1(1'b0, 1'b0, 2'b10, 4'h2, 22'h000000);
    acc1(1'b0, 1'b1, 2'b00, 4'h2, 22'h0);
    chk("we2_rd", q1, 22'h3FF800);
    acc1(1'b1, 1'b1, 2'b11, 4'h0, 22'h0);

    // No-init instance: plain write/read.
    acc3(1'b0, 1'b0, 22'h0, 4'h7, 22'h0ABCDE);
    acc3(1'b0, 1'b1, 22'h0, 4'h7, 22'h0);
    chk("noinit_rd", q3, 22'h0ABCDE);
    acc3(1'b1, 1'b1, 22'h3FFFFF, 4'h0, 22'h0);

    // Pipelined instance: preload, then three back-to-back reads.
    acc2(1'b0, 1'b0, 22'h0, 4'h1, 22'h11);
    acc2(1'b0, 1'b0, 22'h0, 4'h2, 22'h22);
    acc2(1'b0, 1'b0, 22'h0, 4'h3, 22'h33);
    acc2(1'b0, 1'b1, 22'h0, 4'h1, 22'h0);
    chk("pipe_e1", q2, 22'h0);
    acc2(1'b0, 1'b1, 22'h0, 4'h2, 22'h0);
    chk("pipe_e2", q2, 22'h11);
    acc2(1'b0, 1'b1, 22'h0, 4'h3, 22'h0);
    chk("pipe_e3", q2, 22'h22);
    acc2(1'b1, 1'b1, 22'h0, 4'h0, 22'h0);
    chk("pipe_e4", q2, 22'h33);
    acc2(1'b1, 1'b1, 22'h0, 4'h0, 22'h0);
    chk("pipe_hold", q2, 22'h33);
    acc2(1'b0, 1'b1, 22'h0, 4'h5, 22'h0);
    acc2(1'b1, 1'b1, 22'h0, 4'h0, 22'h0);
    chk("pipe_initval", q2, 22'h155555);

    // Asynchronous reset clears outputs immediately.
    rst_n = 1'b0;
    #1;
    chk("arst_q0", q0, 0);
    chk("arst_q2", q2, 0);
    chk("arst_done0", dn0, 0);
    chk("arst_done3", dn3, 1);
    tick();
    rst_n = 1'b1;

    // Mid-init reset, then a full re-initialisation.
    repeat (100) tick();
    chk("mid_init_busy", dn0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done0", dn0, 0);
    chk("mid_rst_q0", q0, 0);
    tick();
    rst_n = 1'b1;
    repeat (511) tick();
    chk("reinit_511", dn0, 0);
    tick();
    chk("reinit_512", dn0, 1);
    acc0(1'b0, 1'b1, 22'h3FFFFF, 9'h050, 22'h0);
    chk("reinit_rd_050", q0, 22'h0);
    acc0(1'b1, 1'b1, 22'h3FFFFF, 9'h0, 22'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_spsram_init_param.md
# ct_spsram_init_param

Parametrised single-port SRAM block for IFU/LSU arrays, generalising the fixed 512x22 wrapper: configurable depth, width and write-enable granularity, optional output pipeline register, hardware clear-on-reset sequencer and read-data hold. It sits between the array controller and the behavioural/FPGA memory. The controller waits for `init_done` before issuing any access.

## Interface
- `ADDR_WIDTH`, 9, address bits; depth `DEPTH = 2**ADDR_WIDTH`
- `DATA_WIDTH`, 22, data bits
- `WE_WIDTH`, 22, write-enable bits; must divide `DATA_WIDTH`. Each `WEN` bit covers `G = DATA_WIDTH/WE_WIDTH` contiguous data bits, with `WEN[i]` covering `D[i*G +: G]`.
- `OUT_REG`, 0, set to 1 to add one output pipeline stage on `Q`
- `INIT_EN`, 1, set to 1 to clear the whole array to `INIT_VAL` after reset
- `INIT_VAL`, 0, `DATA_WIDTH`-bit clear pattern
- `forever_cpuclk`  in  1  single clock; all state updates on its rising edge
- `cpurst_b`  in  1  reset, asynchronous, active-low
- `CEN`  in  1  chip enable, active-low
- `GWEN`  in  1  global write enable, active-low; 0 = write, 1 = read
- `WEN`  in  WE_WIDTH  per-group write enable, active-low
- `A`  in  ADDR_WIDTH  address
- `D`  in  DATA_WIDTH  write data
- `Q`  out  DATA_WIDTH  read data, registered, held between reads
- `init_done`  out  1  high when the array is usable

## Operation
- Sequencer states:
  - `INIT`: reset state when `INIT_EN=1`. Each cycle writes `INIT_VAL` to `mem[init_cnt]` and increments `init_cnt`. When it writes `DEPTH-1` it moves to `DONE`.
  - `DONE`: reset state when `INIT_EN=0`. Terminal until the next reset.
- `init_cnt` is ADDR_WIDTH bits, resets to 0, and does not wrap or advance in `DONE`.
- `init_done` is 1 exactly in `DONE`. Reset value is `INIT_EN ? 0 : 1`.
- External ports while in `INIT`:
  - `CEN`, `GWEN`, `WEN`, `A` and `D` are ignored. No write happens and no read is launched.
  - `Q` holds its reset value.
- Write (in `DONE`, `CEN=0`, `GWEN=0`):
  - For each i with `WEN[i]=0`, `mem[A]` group i takes `D` group i. Other groups are unchanged.
  - All `WEN=1` is a no-op write.
  - `Q` does not change; there is no write-through.
- Read (in `DONE`, `CEN=0`, `GWEN=1`): `mem[A]` is captured into the read register. `WEN` is ignored.
- `CEN=1`: no array access; `Q` holds.
- Array contents have no reset. Only the sequencer clears them, so with `INIT_EN=0` contents are X until written.
- `OUT_REG=1`:
  - A stage-1 valid bit (reset 0) marks a read captured in the previous cycle.
  - The stage-2 register loads from stage 1 only when that bit is set. Otherwise `Q` holds.
- Reset assertion at any time, including mid-`INIT` or mid-pipeline, takes effect immediately:
  - `Q`, the pipeline registers and the valid bit go to 0.
  - The state goes to its reset state and `init_cnt` goes to 0.
  - On deassertion, initialisation restarts from address 0. Partially cleared contents are simply overwritten.

## Timing
- Reset values: `Q`=0, stage-1 register=0, valid=0, `init_done`=`!INIT_EN`.
- Init length: the first clear write happens at the first rising edge after `cpurst_b` rises. `init_done` goes high after exactly `DEPTH` edges (512 at defaults).
- First accepted access: the edge after the one on which `init_done` rises.
- Read latency from the accepting edge:
  - `OUT_REG=0`: `Q` valid after that edge (1 cycle).
  - `OUT_REG=1`: `Q` valid after the next edge (2 cycles).
- Back-to-back reads are accepted every cycle. `Q` delivers one word per cycle in order.
- Read-after-write to the same address on the next cycle returns the new data.
- Read and write in the same cycle is impossible (single port).

## Test plan
- Defaults: release reset, idle for 511 edges -> `init_done`=0. On edge 512 -> `init_done`=1. Read `A`=0x1FF -> `Q`=0x000000 one cycle later.
- Masked write: write 0x3FFFFF to `A`=5. Then write `D`=0 with `WEN`=0x3FF800. Read `A`=5 -> `Q`=0x3FF800. Then hold `CEN=1` for 3 cycles and write `A`=6 -> `Q` stays 0x3FF800 throughout.
- `WE_WIDTH=2`: write 0x3FFFFF with `WEN`=2'b00, then `D`=0 with `WEN`=2'b10 -> readback 0x3FF800.
- `OUT_REG=1`: preload `A`=1/2/3 with 0x11/0x22/0x33. Read `A`=1,2,3 on consecutive cycles -> `Q` = 0x11, 0x22, 0x33 on cycles +2, +3, +4, then holds 0x33.
- During `INIT`: write 0x2AAAAA to `A`=3 -> ignored. After `init_done`, read `A`=3 -> `INIT_VAL`.
- Mid-init reset: assert `cpurst_b`=0 after 100 init edges -> `Q`=0 and `init_done`=0 immediately. After release, `init_done` rises after a full 512 edges, and `A`=0x050 reads `INIT_VAL`.
